// File: rtl/fpga_cfg_pkg.sv
// Shared constants and types for the tile configuration loader.
package fpga_cfg_pkg;

    // Configuration word size and the field layout inside it.
    localparam int TILE_BITS = 77;
    localparam int CLB_MSB   = 76;
    localparam int CLB_LSB   = 54;
    localparam int CBL_LSB   = 36;
    localparam int CTR_LSB   = 18;
    localparam int SB_LSB    = 0;

    // Preamble that precedes the tile frames in the bitstream.
    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    // Loader FSM states; explicit encodings keep the values stable.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } cfg_state_t;

endpackage

// File: rtl/cfg_sync_detect.sv
// Sync-word search: 8-bit sliding window plus a bounded bit counter.
// match_o/timeout_o look ahead at the window/count that the current shift
// would produce, so the loader can change state on the same transfer.
module cfg_sync_detect #(
    parameter logic [7:0] SYNC_WORD    = fpga_cfg_pkg::SYNC_WORD_DEFAULT,
    parameter int         SYNC_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic shift_i,
    input  logic data_i,
    output logic match_o,
    output logic timeout_o
);
    import fpga_cfg_pkg::*;

    localparam int CW = $clog2(SYNC_TIMEOUT + 1);

    logic [7:0]    window_q, window_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Window and count after the incoming bit, and the flags derived from them.
    always_comb begin
        window_d  = {window_q[6:0], data_i};
        cnt_d     = cnt_q + CW'(1);
        match_o   = shift_i && (window_d == SYNC_WORD);
        timeout_o = shift_i && (cnt_d == CW'(SYNC_TIMEOUT));
    end

    // Window/counter registers: cleared on a new load, advanced per accepted bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= 8'h00;
            cnt_q    <= '0;
        end else if (clear_i) begin
            window_q <= 8'h00;
            cnt_q    <= '0;
        end else if (shift_i) begin
            window_q <= window_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/tile_cfg_loader.sv
// Serial configuration front end: finds the sync word, shifts in one
// TILE_BITS frame per tile (MSB first) and strobes that tile's wr_en for one
// cycle while the frame is held on the shared bits bus.
// Handshake: a bit transfers on a rising clk edge where ser_valid_i and
// ser_ready_o are both high; ser_ready_o depends only on state, never on valid.
module tile_cfg_loader #(
    parameter int         NUM_TILES    = 4,
    parameter int         TILE_BITS    = fpga_cfg_pkg::TILE_BITS,
    parameter logic [7:0] SYNC_WORD    = fpga_cfg_pkg::SYNC_WORD_DEFAULT,
    parameter int         SYNC_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 ser_data_i,
    input  logic                 ser_valid_i,
    output logic                 ser_ready_o,
    output logic [TILE_BITS-1:0] bits_o,
    output logic [NUM_TILES-1:0] wr_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    import fpga_cfg_pkg::*;

    localparam int BCW = $clog2(TILE_BITS);
    localparam int TW  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    cfg_state_t           state_q, state_d;
    logic [TILE_BITS-1:0] bits_q, bits_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]        tile_idx_q, tile_idx_d;

    logic xfer;
    logic start_ok;
    logic sync_shift;
    logic sync_match;
    logic sync_timeout;

    assign ser_ready_o = (state_q == ST_SYNC) || (state_q == ST_LOAD);
    assign xfer        = ser_valid_i && ser_ready_o;
    assign start_ok    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                     (state_q == ST_ERROR));
    assign sync_shift  = xfer && (state_q == ST_SYNC);

    cfg_sync_detect #(
        .SYNC_WORD   (SYNC_WORD),
        .SYNC_TIMEOUT(SYNC_TIMEOUT)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (start_ok),
        .shift_i  (sync_shift),
        .data_i   (ser_data_i),
        .match_o  (sync_match),
        .timeout_o(sync_timeout)
    );

    // Next-state logic for the FSM, frame shifter and counters.
    always_comb begin
        state_d    = state_q;
        bits_d     = bits_q;
        bit_cnt_d  = bit_cnt_q;
        tile_idx_d = tile_idx_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_ok) begin
                    state_d    = ST_SYNC;
                    bit_cnt_d  = '0;
                    tile_idx_d = '0;
                end
            end
            ST_SYNC: begin
                if (sync_match) begin
                    state_d = ST_LOAD;
                end else if (sync_timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    bits_d = {bits_q[TILE_BITS-2:0], ser_data_i};
                    if (bit_cnt_q == BCW'(TILE_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_WRITE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            ST_WRITE: begin
                if (tile_idx_q == TW'(NUM_TILES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    tile_idx_d = tile_idx_q + TW'(1);
                    state_d    = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bits_q     <= '0;
            bit_cnt_q  <= '0;
            tile_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            bits_q     <= bits_d;
            bit_cnt_q  <= bit_cnt_d;
            tile_idx_q <= tile_idx_d;
        end
    end

    // Strobe decoded from state so reset removes it without waiting for a clock.
    always_comb begin
        wr_en_o = '0;
        if (state_q == ST_WRITE) begin
            wr_en_o[tile_idx_q] = 1'b1;
        end
    end

    assign bits_o = bits_q;
    assign busy_o = (state_q == ST_SYNC) || (state_q == ST_LOAD) || (state_q == ST_WRITE);
    assign done_o = (state_q == ST_DONE);
    assign err_o  = (state_q == ST_ERROR);

endmodule

// File: doc/tile_cfg_loader.md
Name: tile_cfg_loader

Overview:
Configuration front end for the tile array. It receives the serial bitstream, searches for a sync word, and assembles each tile's 77-bit configuration word. It then pulses the matching tile's wr_en for one cycle while the word is held stable on the shared bits bus. It is the stage directly upstream of every Tile's bits/wr_en inputs.

Parameters:
NUM_TILES, 4, number of tiles configured; tile 0 first.
TILE_BITS, 77, configuration bits per tile (CLB 76:54, Cblock BL 53:36, Cblock TR 35:18, Sblock 17:0).
SYNC_WORD, 8'hA5, preamble that must precede the tile frames.
SYNC_TIMEOUT, 64, accepted bits allowed in the sync search before error.

Ports:
clk  in  1  single clock.
rst  in  1  asynchronous active-high reset.
start_i  in  1  begin a load; sampled only in IDLE, DONE or ERROR.
ser_data_i  in  1  serial bitstream data.
ser_valid_i  in  1  ser_data_i valid.
ser_ready_o  out  1  loader can accept a bit; a bit transfers when valid & ready.
bits_o  out  TILE_BITS  shared configuration bus to all tiles.
wr_en_o  out  NUM_TILES  one-hot write strobe, bit k drives tile k's wr_en.
busy_o  out  1  high in SYNC, LOAD and WRITE.
done_o  out  1  level: all tiles written.
err_o  out  1  level: sync timeout.

Behaviour:
- Reset (async, any state): state=IDLE, bits_o=0, wr_en_o=0, ser_ready_o=0, busy_o=0, done_o=0, err_o=0, all counters=0.
- States: IDLE, SYNC, LOAD, WRITE, DONE, ERROR. All outputs are registered or decoded from state; ser_ready_o is combinational from state.
- IDLE/DONE/ERROR:
  - On start_i: go to SYNC, clear done_o, err_o, the 8-bit sync window, the sync counter, the bit counter and the tile index.
  - start_i is ignored in SYNC, LOAD and WRITE.
- SYNC (ser_ready_o=1):
  - On each transfer: window <= {window[6:0], ser_data_i}; sync counter increments.
  - If the new window equals SYNC_WORD, go to LOAD next cycle.
  - Otherwise, if the sync counter reaches SYNC_TIMEOUT with this transfer, go to ERROR. A match on the same transfer wins over timeout.
  - Window starts at 8'h00.
- LOAD (ser_ready_o=1):
  - On each transfer: bits_o <= {bits_o[TILE_BITS-2:0], ser_data_i}. The first bit after sync ends up in bits_o[TILE_BITS-1] (MSB first).
  - The bit counter counts 0..TILE_BITS-1. On the TILE_BITS-th transfer, the counter clears and the state goes to WRITE.
  - Idle cycles (valid low) do not advance anything.
- WRITE (ser_ready_o=0): exactly one cycle.
  - wr_en_o = 1 << tile_idx; bits_o is unchanged.
  - Next state is DONE if tile_idx==NUM_TILES-1, else tile_idx++ and return to LOAD.
- DONE: done_o=1, ser_ready_o=0, wr_en_o=0, bits_o holds the last tile's word.
- ERROR: err_o=1, ser_ready_o=0, no write strobe ever issued.
- Invariants:
  - At most one wr_en_o bit is high in any cycle, and only in WRITE.
  - bits_o never changes in a cycle where wr_en_o≠0.
- Reset mid-LOAD or mid-WRITE: the strobe drops asynchronously and tiles already written keep their contents. A later start reloads from tile 0.
- Counter widths: $clog2(TILE_BITS) for the bit counter, $clog2(NUM_TILES) (minimum 1) for the tile index, $clog2(SYNC_TIMEOUT+1) for the sync counter.
- Latency: the write strobe occurs in the cycle after the last bit of a frame transfers. A back-to-back stream loses one cycle per tile, during which ready is low.

Decomposition:
- Package fpga_cfg_pkg:
  - TILE_BITS;
  - field offset constants (CLB_MSB=76, CLB_LSB=54, CBL_LSB=36, CTR_LSB=18, SB_LSB=0);
  - default SYNC_WORD;
  - the state enum cfg_state_t.
- One sub-module: cfg_sync_detect, which holds the 8-bit window, the timeout counter and the match/timeout flags, with clear and shift-enable inputs.

Test Plan:
1. Reset, start_i, stream 8'hA5 then 4×77 bits (tile k = 77'h1 << k, MSB first), valid always high -> exactly four 1-cycle strobes with wr_en_o=0001,0010,0100,1000 and bits_o=that tile's word during each; ser_ready_o low only in those cycles; done_o=1 afterwards.
2. Stream 5 garbage bits (1,0,1,1,1) then A5 then frames -> the sync match occurs on the 13th bit; frames load as in test 1.
3. Stream 64 zeros after start -> err_o=1 after the 64th transfer, wr_en_o never asserted, ser_ready_o=0; a new start_i clears err_o.
4. Toggle ser_valid_i every other cycle during LOAD -> identical bits_o/wr_en_o sequence to test 1, at half rate.
5. Assert rst during tile 2's frame (bit 40) -> all outputs 0 immediately; start plus a full stream then reproduces test 1.
6. Pulse start_i during LOAD -> ignored: tile index and bit count are unaffected, and all four strobes still occur.
